sobel_stream_engine: RTL

Streaming 3x3 Sobel edge-magnitude engine. It sits directly downstream of the SPI control block's gray-pixel output and upstream of its Sobel-result input. It accepts one raster-order gray pixel per px_valid_i strobe and keeps two line buffers plus a 3x3 window. It emits one saturated |Gx|+|Gy| pixel per accepted input pixel at fixed latency.

---
 rtl/sobel_stream_engine.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge-magnitude engine: raster gray pixels in, saturated
// |Gx|+|Gy| out, two pipeline stages, one result per accepted pixel.
`timescale 1ns/1ps
module sobel_stream_engine #(
  parameter int unsigned MAX_PIXEL_BITS = 8,
  parameter int unsigned IMG_WIDTH      = 8,
  parameter int unsigned IMG_HEIGHT     = 8
) (
  input  logic                      clk_i,
  input  logic                      nreset_i,
  input  logic                      px_valid_i,
  input  logic [MAX_PIXEL_BITS-1:0] input_px_gray_i,
  input  logic                      frame_start_i,
  output logic [MAX_PIXEL_BITS-1:0] output_px_sobel_o,
  output logic                      px_valid_o,
  output logic                      frame_done_o
);

  localparam int unsigned PW = MAX_PIXEL_BITS;
  localparam int unsigned CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned SW = PW + 3;
  localparam int unsigned MW = PW + 4;
  localparam logic [PW-1:0] PX_MAX  = '1;
  localparam logic [MW-1:0] MAG_MAX = MW'(PX_MAX);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [CW-1:0] pos_col_c;
  logic [RW-1:0] pos_row_c;
  logic          last_col_c;
  logic          last_row_c;
  logic [PW-1:0] lb0_rd_c;
  logic [PW-1:0] lb1_rd_c;

  logic [PW-1:0] lb0 [IMG_WIDTH];
  logic [PW-1:0] lb1 [IMG_WIDTH];

  logic [PW-1:0] win_q [3][3];
  logic          s1_valid_q;
  logic          s1_mask_q;
  logic          s1_last_q;

  logic signed [SW-1:0] px_c [3][3];
  logic signed [SW-1:0] gx_c;
  logic signed [SW-1:0] gy_c;
  logic        [SW-1:0] ax_c;
  logic        [SW-1:0] ay_c;
  logic        [MW-1:0] mag_c;
  logic        [PW-1:0] sat_c;

  // Position of the pixel on the input this cycle; frame_start_i overrides
  always_comb begin
    pos_col_c  = frame_start_i ? '0 : col_q;
    pos_row_c  = frame_start_i ? '0 : row_q;
    last_col_c = (pos_col_c == CW'(IMG_WIDTH - 1));
    last_row_c = (pos_row_c == RW'(IMG_HEIGHT - 1));
    lb0_rd_c   = lb0[pos_col_c];
    lb1_rd_c   = lb1[pos_col_c];
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (px_valid_i) begin
      if (last_col_c) begin
        col_q <= '0;
        row_q <= last_row_c ? '0 : pos_row_c + RW'(1);
      end else begin
        col_q <= pos_col_c + CW'(1);
        row_q <= pos_row_c;
      end
    end else if (frame_start_i) begin
      col_q <= '0;
      row_q <= '0;
    end
  end

  // Line buffers carry no reset; the border mask hides stale contents
  always_ff @(posedge clk_i) begin
    if (px_valid_i) begin
      lb0[pos_col_c] <= lb1_rd_c;
      lb1[pos_col_c] <= input_px_gray_i;
    end
  end

  // Stage 1: window shift plus border mask and end-of-frame flag
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
      s1_valid_q <= 1'b0;
      s1_mask_q  <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= px_valid_i;
      if (px_valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb0_rd_c;
        win_q[1][2] <= lb1_rd_c;
        win_q[2][2] <= input_px_gray_i;
        s1_mask_q   <= (pos_row_c >= RW'(2)) && (pos_col_c >= CW'(2));
        s1_last_q   <= last_row_c && last_col_c;
      end
    end
  end

  // Gradient arithmetic; row 0 is the oldest row, column 0 the oldest column
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        px_c[r][c] = $signed(SW'(win_q[r][c]));
      end
    end
    gx_c  = (px_c[0][2] + (px_c[1][2] <<< 1) + px_c[2][2])
          - (px_c[0][0] + (px_c[1][0] <<< 1) + px_c[2][0]);
    gy_c  = (px_c[2][0] + (px_c[2][1] <<< 1) + px_c[2][2])
          - (px_c[0][0] + (px_c[0][1] <<< 1) + px_c[0][2]);
    ax_c  = gx_c[SW-1] ? SW'(-gx_c) : SW'(gx_c);
    ay_c  = gy_c[SW-1] ? SW'(-gy_c) : SW'(gy_c);
    mag_c = MW'(ax_c) + MW'(ay_c);
    sat_c = (mag_c > MAG_MAX) ? PX_MAX : mag_c[PW-1:0];
  end

  // Stage 2: registered result, held between valid strobes
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      output_px_sobel_o <= '0;
      px_valid_o        <= 1'b0;
      frame_done_o      <= 1'b0;
    end else begin
      px_valid_o   <= s1_valid_q;
      frame_done_o <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        output_px_sobel_o <= s1_mask_q ? sat_c : '0;
      end
    end
  end

endmodule
